// File: rtl/audio_pkg.sv
// Shared audio-path constants and sample/word types used by the codec,
// decimator and FFT front end.
package audio_pkg;

    localparam int AUDIO_W      = 16;
    localparam int FFT_W        = 32;
    localparam int FFT_FRAC_PAD = 8;
    localparam int DECIM_LOG2   = 6;

    typedef logic signed [AUDIO_W-1:0] audio_sample_t;
    typedef logic        [FFT_W-1:0]   fft_word_t;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register. A load in the same cycle as a
// transfer wins, so a back-to-back producer never loses a word.
module stream_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/audio_decimator.sv
// Decimates the codec sample stream by 2^LOG2_DECIM (pick-last or block mean)
// and formats each result as an FFT input word; counts samples lost to back-pressure.
module audio_decimator
    import audio_pkg::*;
#(
    parameter int N_IN       = AUDIO_W,
    parameter int W_OUT      = FFT_W,
    parameter int FRAC_PAD   = FFT_FRAC_PAD,
    parameter int LOG2_DECIM = DECIM_LOG2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [N_IN-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W_OUT-1:0]       out_data,
    output logic [15:0]            drop_count
);

    localparam int ACC_W = N_IN + LOG2_DECIM;
    localparam logic [LOG2_DECIM-1:0] LAST = {LOG2_DECIM{1'b1}};

    logic [LOG2_DECIM-1:0]     idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      mode_q, mode_d;
    logic [15:0]               drop_q, drop_d;

    logic                      accept;
    logic                      load;
    logic signed [ACC_W-1:0]   in_ext;
    logic signed [ACC_W-1:0]   sum;
    logic signed [N_IN-1:0]    result;
    logic [W_OUT-1:0]          word;

    // Only the block-completing sample can be blocked by a full output register.
    assign in_ready = !(idx_q == LAST && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && (idx_q == LAST);

    assign in_ext = {{LOG2_DECIM{in_data[N_IN-1]}}, in_data};
    assign sum    = acc_q + in_ext;
    // Arithmetic shift floors toward -inf; the mean always fits in N_IN bits.
    assign result = mode_q ? N_IN'(sum >>> LOG2_DECIM) : in_data;
    assign word   = {{(W_OUT-N_IN-FRAC_PAD){result[N_IN-1]}}, result, {FRAC_PAD{1'b0}}};

    always_comb begin
        idx_d  = idx_q;
        acc_d  = acc_q;
        mode_d = mode_q;
        drop_d = drop_q;
        if (accept) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == '0) begin
                acc_d  = in_ext;
                mode_d = mode;
            end else begin
                acc_d = sum;
            end
        end
        if (in_valid && !in_ready && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            acc_q  <= '0;
            mode_q <= 1'b0;
            drop_q <= '0;
        end else begin
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            mode_q <= mode_d;
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;

    stream_out_reg #(
        .W (W_OUT)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .load_data_i (word),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data)
    );

endmodule

// File: tb/tb_audio_decimator.sv
// Directed bench for audio_decimator: pick/average results, back-pressure
// drops, reset mid-block and mid-block mode changes.
`timescale 1ns/1ps
module tb_audio_decimator;
    import audio_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    audio_sample_t in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    fft_word_t     out_data;
    logic [15:0]   drop_count;

    int checks = 0;
    int errors = 0;

    always #27 clk = ~clk;

    audio_decimator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_count (drop_count)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
        repeat (2) @(posedge clk);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic push(input audio_sample_t d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #5;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            $display("FAIL reset_out: valid=%b data=%h want 0/00000000", out_valid, out_data); errors++;
        end
        checks++;
        if (in_ready !== 1'b1 || drop_count !== 16'h0) begin
            $display("FAIL reset_misc: in_ready=%b drop=%h want 1/0000", in_ready, drop_count); errors++;
        end
        do_reset();
    endtask

    task automatic test_pick_ramp();
        do_reset();
        mode = 1'b0;
        for (int i = 0; i < 64; i++) push(audio_sample_t'(i));
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00003F00) begin
            $display("FAIL pick_block0: valid=%b data=%h want 1/00003F00", out_valid, out_data); errors++;
        end
        push(16'sd64);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL pick_drain: valid=%b want 0", out_valid); errors++;
        end
        for (int i = 65; i < 128; i++) push(audio_sample_t'(i));
        idle();
        checks++;
        if (out_data !== 32'h00007F00) begin
            $display("FAIL pick_block1: data=%h want 00007F00", out_data); errors++;
        end
        checks++;
        if (drop_count !== 16'h0) begin
            $display("FAIL pick_drop: drop=%h want 0000", drop_count); errors++;
        end
    endtask

    task automatic test_average();
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 63; i++) push(-16'sd1000);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL avg_early: valid=%b want 0", out_valid); errors++;
        end
        push(-16'sd1000);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFC1800) begin
            $display("FAIL avg_neg1000: valid=%b data=%h want 1/FFFC1800", out_valid, out_data); errors++;
        end
        for (int i = 0; i < 64; i++) push((i % 2 == 0) ? 16'sd32767 : -16'sd32768);
        checks++;
        if (out_data !== 32'hFFFFFF00) begin
            $display("FAIL avg_floor_neg: data=%h want FFFFFF00", out_data); errors++;
        end
        for (int i = 0; i < 63; i++) push(16'sd1);
        push(16'sd0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000000) begin
            $display("FAIL avg_floor_pos: valid=%b data=%h want 1/00000000", out_valid, out_data); errors++;
        end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) push(audio_sample_t'(i));
        for (int i = 64; i < 127; i++) push(audio_sample_t'(i));
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00003F00) begin
            $display("FAIL bp_held: valid=%b data=%h want 1/00003F00", out_valid, out_data); errors++;
        end
        in_valid = 1'b1; in_data = 16'sd127;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL bp_in_ready: in_ready=%b want 0", in_ready); errors++;
        end
        for (int i = 0; i < 3; i++) push(16'sd127);
        checks++;
        if (drop_count !== 16'd3) begin
            $display("FAIL bp_drop_count: drop=%0d want 3", drop_count); errors++;
        end
        out_ready = 1'b1;
        push(16'sd200);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000C800) begin
            $display("FAIL bp_new_word: valid=%b data=%h want 1/0000C800", out_valid, out_data); errors++;
        end
        idle();
        checks++;
        if (out_valid !== 1'b0 || drop_count !== 16'd3) begin
            $display("FAIL bp_drain: valid=%b drop=%0d want 0/3", out_valid, drop_count); errors++;
        end
    endtask

    task automatic test_reset_mid_block();
        int n_out;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 64 + 30; i++) push(16'sd9);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL rst_mid_valid: valid=%b want 0", out_valid); errors++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        mode = 1'b1;
        n_out = 0;
        for (int i = 0; i < 64; i++) begin
            push(16'sd5);
            if (out_valid) n_out++;
        end
        checks++;
        if (out_data !== 32'h00000500) begin
            $display("FAIL rst_mid_data: data=%h want 00000500", out_data); errors++;
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            if (out_valid) n_out++;
        end
        checks++;
        if (n_out != 1) begin
            $display("FAIL rst_mid_count: outputs=%0d want 1", n_out); errors++;
        end
    endtask

    task automatic test_mode_change();
        do_reset();
        mode = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 10) mode = 1'b1;
            push(audio_sample_t'(i));
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00003F00) begin
            $display("FAIL mode_pick_block: valid=%b data=%h want 1/00003F00", out_valid, out_data); errors++;
        end
        for (int i = 64; i < 128; i++) push(audio_sample_t'(i));
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00005F00) begin
            $display("FAIL mode_avg_block: valid=%b data=%h want 1/00005F00", out_valid, out_data); errors++;
        end
        idle();
    endtask

    initial begin
        #5;
        test_reset();
        test_pick_ramp();
        test_average();
        test_backpressure();
        test_reset_mid_block();
        test_mode_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
